// File: rtl/decode_stage_if.sv
// Pipeline signals around the Y86-64 decode stage: fetch->decode inputs,
// forwarding/write-back sources, E-register controls and the E register outputs.
interface decode_stage_if;
    logic [3:0]  d_icode;
    logic [3:0]  d_ifun;
    logic [3:0]  d_rA;
    logic [3:0]  d_rB;
    logic [63:0] d_valC;
    logic [63:0] d_valP;
    logic [3:0]  e_dstE;
    logic [63:0] e_valE;
    logic [3:0]  M_dstE;
    logic [63:0] M_valE;
    logic [3:0]  M_dstM;
    logic [63:0] m_valM;
    logic [3:0]  W_dstE;
    logic [63:0] W_valE;
    logic [3:0]  W_dstM;
    logic [63:0] W_valM;
    logic        E_stall;
    logic        E_bubble;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [3:0]  E_icode;
    logic [3:0]  E_ifun;
    logic [63:0] E_valC;
    logic [63:0] E_valA;
    logic [63:0] E_valB;
    logic [3:0]  E_dstE;
    logic [3:0]  E_dstM;
    logic [3:0]  E_srcA;
    logic [3:0]  E_srcB;

    // Handshake: none. E_stall/E_bubble are level controls sampled on each
    // rising edge; bubble overrides stall, and every other input is consumed
    // in the cycle it is presented.
    modport master (
        output d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP,
        output e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
        output W_dstE, W_valE, W_dstM, W_valM, E_stall, E_bubble,
        input  d_srcA, d_srcB, E_icode, E_ifun, E_valC, E_valA, E_valB,
        input  E_dstE, E_dstM, E_srcA, E_srcB
    );

    modport slave (
        input  d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP,
        input  e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
        input  W_dstE, W_valE, W_dstM, W_valM, E_stall, E_bubble,
        output d_srcA, d_srcB, E_icode, E_ifun, E_valC, E_valA, E_valB,
        output E_dstE, E_dstM, E_srcA, E_srcB
    );
endinterface

// File: rtl/decode_stage.sv
// Y86-64 decode stage: register file, source/destination decode, E/M/W
// forwarding and the decode->execute pipeline register.
module decode_stage (
    input  logic          clk,
    input  logic          rst_n,
    decode_stage_if.slave dif
);
    localparam logic [3:0] RNONE     = 4'hF;
    localparam logic [3:0] RSP       = 4'h4;
    localparam logic [3:0] NOP_ICODE = 4'h1;

    logic [63:0] rf_q [0:14];
    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic [63:0] rf_a, rf_b, val_a, val_b;

    logic [3:0]  e_icode_q, e_ifun_q, e_dste_q, e_dstm_q, e_srca_q, e_srcb_q;
    logic [63:0] e_valc_q, e_vala_q, e_valb_q;

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (dif.d_icode)
            4'h2: begin src_a = dif.d_rA; dst_e = dif.d_rB; end
            4'h3: dst_e = dif.d_rB;
            4'h4: begin src_a = dif.d_rA; src_b = dif.d_rB; end
            4'h5: begin src_b = dif.d_rB; dst_m = dif.d_rA; end
            4'h6: begin src_a = dif.d_rA; src_b = dif.d_rB; dst_e = dif.d_rB; end
            4'h8: begin src_b = RSP; dst_e = RSP; end
            4'h9: begin src_a = RSP; src_b = RSP; dst_e = RSP; end
            4'hA: begin src_a = dif.d_rA; src_b = RSP; dst_e = RSP; end
            4'hB: begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = dif.d_rA; end
            default: ;
        endcase
    end

    assign dif.d_srcA = src_a;
    assign dif.d_srcB = src_b;

    // RNONE reads as zero; it can never match a destination since the
    // forwarding compares below exclude it explicitly.
    assign rf_a = (src_a == RNONE) ? 64'd0 : rf_q[src_a];
    assign rf_b = (src_b == RNONE) ? 64'd0 : rf_q[src_b];

    always_comb begin
        val_a = rf_a;
        if (dif.d_icode == 4'h7 || dif.d_icode == 4'h8)          val_a = dif.d_valP;
        else if (src_a != RNONE && src_a == dif.e_dstE)           val_a = dif.e_valE;
        else if (src_a != RNONE && src_a == dif.M_dstM)           val_a = dif.m_valM;
        else if (src_a != RNONE && src_a == dif.M_dstE)           val_a = dif.M_valE;
        else if (src_a != RNONE && src_a == dif.W_dstM)           val_a = dif.W_valM;
        else if (src_a != RNONE && src_a == dif.W_dstE)           val_a = dif.W_valE;
    end

    always_comb begin
        val_b = rf_b;
        if (src_b != RNONE && src_b == dif.e_dstE)                val_b = dif.e_valE;
        else if (src_b != RNONE && src_b == dif.M_dstM)           val_b = dif.m_valM;
        else if (src_b != RNONE && src_b == dif.M_dstE)           val_b = dif.M_valE;
        else if (src_b != RNONE && src_b == dif.W_dstM)           val_b = dif.W_valM;
        else if (src_b != RNONE && src_b == dif.W_dstE)           val_b = dif.W_valE;
    end

    // W_valM takes precedence when both ports target one register (popq %rsp).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) rf_q[i] <= 64'd0;
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (dif.W_dstM == 4'(i))      rf_q[i] <= dif.W_valM;
                else if (dif.W_dstE == 4'(i)) rf_q[i] <= dif.W_valE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || dif.E_bubble) begin
            e_icode_q <= NOP_ICODE;
            e_ifun_q  <= 4'h0;
            e_valc_q  <= 64'd0;
            e_vala_q  <= 64'd0;
            e_valb_q  <= 64'd0;
            e_dste_q  <= RNONE;
            e_dstm_q  <= RNONE;
            e_srca_q  <= RNONE;
            e_srcb_q  <= RNONE;
        end else if (!dif.E_stall) begin
            e_icode_q <= dif.d_icode;
            e_ifun_q  <= dif.d_ifun;
            e_valc_q  <= dif.d_valC;
            e_vala_q  <= val_a;
            e_valb_q  <= val_b;
            e_dste_q  <= dst_e;
            e_dstm_q  <= dst_m;
            e_srca_q  <= src_a;
            e_srcb_q  <= src_b;
        end
    end

    assign dif.E_icode = e_icode_q;
    assign dif.E_ifun  = e_ifun_q;
    assign dif.E_valC  = e_valc_q;
    assign dif.E_valA  = e_vala_q;
    assign dif.E_valB  = e_valb_q;
    assign dif.E_dstE  = e_dste_q;
    assign dif.E_dstM  = e_dstm_q;
    assign dif.E_srcA  = e_srca_q;
    assign dif.E_srcB  = e_srcb_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table for decode/forwarding plus
// hand sequences for write-back, stall/bubble and mid-stream reset.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_errors = 0;

    decode_stage_if dif ();

    decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dif   (dif)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  icode, ifun, rA, rB;
        logic [63:0] valC, valP;
        logic [3:0]  e_dstE;  logic [63:0] e_valE;
        logic [3:0]  M_dstE;  logic [63:0] M_valE;
        logic [3:0]  M_dstM;  logic [63:0] m_valM;
        logic [3:0]  W_dstE;  logic [63:0] W_valE;
        logic [3:0]  W_dstM;  logic [63:0] W_valM;
        logic [3:0]  x_srcA, x_srcB, x_dstE, x_dstM;
        logic [63:0] x_valA, x_valB;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t blank(input string name, input logic [3:0] icode,
                                   input logic [3:0] rA, input logic [3:0] rB);
        vec_t v;
        v.name = name; v.icode = icode; v.ifun = 4'h0; v.rA = rA; v.rB = rB;
        v.valC = 64'h0; v.valP = 64'h0;
        v.e_dstE = 4'hF; v.e_valE = 64'h0; v.M_dstE = 4'hF; v.M_valE = 64'h0;
        v.M_dstM = 4'hF; v.m_valM = 64'h0; v.W_dstE = 4'hF; v.W_valE = 64'h0;
        v.W_dstM = 4'hF; v.W_valM = 64'h0;
        v.x_srcA = 4'hF; v.x_srcB = 4'hF; v.x_dstE = 4'hF; v.x_dstM = 4'hF;
        v.x_valA = 64'h0; v.x_valB = 64'h0;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        dif.d_icode = v.icode; dif.d_ifun = v.ifun; dif.d_rA = v.rA; dif.d_rB = v.rB;
        dif.d_valC = v.valC; dif.d_valP = v.valP;
        dif.e_dstE = v.e_dstE; dif.e_valE = v.e_valE;
        dif.M_dstE = v.M_dstE; dif.M_valE = v.M_valE;
        dif.M_dstM = v.M_dstM; dif.m_valM = v.m_valM;
        dif.W_dstE = v.W_dstE; dif.W_valE = v.W_valE;
        dif.W_dstM = v.W_dstM; dif.W_valM = v.W_valM;
    endtask

    // Drive at the falling edge, check combinational IDs, clock, check E_*.
    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        chk({v.name, ".d_srcA"}, 64'(dif.d_srcA), 64'(v.x_srcA));
        chk({v.name, ".d_srcB"}, 64'(dif.d_srcB), 64'(v.x_srcB));
        @(posedge clk);
        #1;
        chk({v.name, ".E_icode"}, 64'(dif.E_icode), 64'(v.icode));
        chk({v.name, ".E_ifun"},  64'(dif.E_ifun),  64'(v.ifun));
        chk({v.name, ".E_valC"},  dif.E_valC, v.valC);
        chk({v.name, ".E_valA"},  dif.E_valA, v.x_valA);
        chk({v.name, ".E_valB"},  dif.E_valB, v.x_valB);
        chk({v.name, ".E_dstE"},  64'(dif.E_dstE), 64'(v.x_dstE));
        chk({v.name, ".E_dstM"},  64'(dif.E_dstM), 64'(v.x_dstM));
        chk({v.name, ".E_srcA"},  64'(dif.E_srcA), 64'(v.x_srcA));
        chk({v.name, ".E_srcB"},  64'(dif.E_srcB), 64'(v.x_srcB));
    endtask

    task automatic wb(input logic [3:0] de, input logic [63:0] ve,
                      input logic [3:0] dm, input logic [63:0] vm);
        vec_t v;
        v = blank("wb", 4'h1, 4'hF, 4'hF);
        v.W_dstE = de; v.W_valE = ve; v.W_dstM = dm; v.W_valM = vm;
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string name);
        chk({name, ".E_icode"}, 64'(dif.E_icode), 64'h1);
        chk({name, ".E_valA"},  dif.E_valA, 64'h0);
        chk({name, ".E_dstE"},  64'(dif.E_dstE), 64'hF);
        chk({name, ".E_dstM"},  64'(dif.E_dstM), 64'hF);
        chk({name, ".E_srcA"},  64'(dif.E_srcA), 64'hF);
        chk({name, ".E_srcB"},  64'(dif.E_srcB), 64'hF);
    endtask

    initial begin
        vec_t v;
        dif.E_stall = 1'b0;
        dif.E_bubble = 1'b0;
        drive(blank("idle", 4'h1, 4'hF, 4'hF));
        repeat (2) @(posedge clk);
        #1;
        chk_bubble("reset");
        @(negedge clk);
        rst_n = 1'b1;

        wb(4'h3, 64'h55, 4'hF, 64'h0);
        wb(4'h4, 64'h200, 4'hF, 64'h0);

        v = blank("opq", 4'h6, 4'h3, 4'h3); v.ifun = 4'h1;
        v.x_srcA = 4'h3; v.x_srcB = 4'h3; v.x_dstE = 4'h3; v.x_valA = 64'h55; v.x_valB = 64'h55;
        vecs.push_back(v);
        v = blank("call", 4'h8, 4'hF, 4'hF); v.valC = 64'hABC; v.valP = 64'h100;
        v.x_srcB = 4'h4; v.x_dstE = 4'h4; v.x_valA = 64'h100; v.x_valB = 64'h200;
        vecs.push_back(v);
        v = blank("fwd_e", 4'h2, 4'h2, 4'h5);
        v.e_dstE = 4'h2; v.e_valE = 64'h11; v.M_dstM = 4'h2; v.m_valM = 64'h22;
        v.W_dstE = 4'h2; v.W_valE = 64'h33;
        v.x_srcA = 4'h2; v.x_dstE = 4'h5; v.x_valA = 64'h11;
        vecs.push_back(v);
        v.name = "fwd_m"; v.e_dstE = 4'hF; v.x_valA = 64'h22;
        vecs.push_back(v);
        v = blank("mrmov_fwd_ME", 4'h5, 4'h7, 4'h3); v.valC = 64'h18;
        v.M_dstE = 4'h3; v.M_valE = 64'h77;
        v.x_srcB = 4'h3; v.x_dstM = 4'h7; v.x_valB = 64'h77;
        vecs.push_back(v);
        v = blank("push_fwd_WM", 4'hA, 4'h2, 4'hF);
        v.W_dstM = 4'h4; v.W_valM = 64'h300;
        v.x_srcA = 4'h2; v.x_srcB = 4'h4; v.x_dstE = 4'h4; v.x_valA = 64'h33; v.x_valB = 64'h300;
        vecs.push_back(v);
        v = blank("popq", 4'hB, 4'h6, 4'hF);
        v.x_srcA = 4'h4; v.x_srcB = 4'h4; v.x_dstE = 4'h4; v.x_dstM = 4'h6;
        v.x_valA = 64'h300; v.x_valB = 64'h300;
        vecs.push_back(v);
        v = blank("ret", 4'h9, 4'hF, 4'hF); v.valP = 64'h77;
        v.x_srcA = 4'h4; v.x_srcB = 4'h4; v.x_dstE = 4'h4; v.x_valA = 64'h300; v.x_valB = 64'h300;
        vecs.push_back(v);
        v = blank("jxx", 4'h7, 4'hF, 4'hF); v.ifun = 4'h3; v.valC = 64'h500; v.valP = 64'h40;
        v.x_valA = 64'h40;
        vecs.push_back(v);
        v = blank("irmov", 4'h3, 4'hF, 4'h9); v.valC = 64'h1234;
        v.x_dstE = 4'h9;
        vecs.push_back(v);
        v = blank("undef_C", 4'hC, 4'h3, 4'h3); v.e_dstE = 4'hF; v.e_valE = 64'hDEAD;
        vecs.push_back(v);
        v = blank("rmmov_wb_same", 4'h4, 4'h3, 4'h4);
        v.W_dstE = 4'h3; v.W_valE = 64'h99;
        v.x_srcA = 4'h3; v.x_srcB = 4'h4; v.x_valA = 64'h99; v.x_valB = 64'h300;
        vecs.push_back(v);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        wb(4'h4, 64'h8, 4'h4, 64'h9);
        v = blank("dual_wr_ret", 4'h9, 4'hF, 4'hF);
        v.x_srcA = 4'h4; v.x_srcB = 4'h4; v.x_dstE = 4'h4; v.x_valA = 64'h9; v.x_valB = 64'h9;
        apply(v);

        @(negedge clk);
        drive(blank("stall_in", 4'h6, 4'h3, 4'h3));
        dif.E_stall = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("stall.E_icode", 64'(dif.E_icode), 64'h9);
        chk("stall.E_valA", dif.E_valA, 64'h9);
        chk("stall.E_srcA", 64'(dif.E_srcA), 64'h4);
        @(negedge clk);
        dif.E_bubble = 1'b1;
        @(posedge clk);
        #1;
        chk_bubble("stall_bubble");
        @(negedge clk);
        dif.E_stall = 1'b0;
        dif.E_bubble = 1'b0;

        v = blank("pre_reset", 4'h6, 4'h3, 4'h3);
        v.x_srcA = 4'h3; v.x_srcB = 4'h3; v.x_dstE = 4'h3; v.x_valA = 64'h99; v.x_valB = 64'h99;
        apply(v);
        #2;
        rst_n = 1'b0;
        #1;
        chk_bubble("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        v.name = "post_reset"; v.x_valA = 64'h0; v.x_valB = 64'h0;
        apply(v);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
